// File: rtl/cpu_ctrl_if.sv
// ROM fetch and datapath control bus between cpu_ctrl and the 8-bit datapath.
// master = sequencer side, slave = ROM/datapath side.
interface cpu_ctrl_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pc_o;
    logic [15:0]     instr_i;
    logic [5:0]      cc_i;
    logic            wrA;
    logic [1:0]      selA;
    logic [1:0]      selB;
    logic [1:0]      aluOp;
    logic            imm;
    logic [1:0]      selR;

    modport master (
        output pc_o, wrA, selA, selB, aluOp, imm, selR,
        input  instr_i, cc_i
    );

    modport slave (
        input  pc_o, wrA, selA, selB, aluOp, imm, selR,
        output instr_i, cc_i
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Fetch/decode/exec sequencer for the 8-bit datapath, 3 cycles per instruction.
// Optional retired-instruction counter enabled by macro CPU_CTRL_PERF_EN.
module cpu_ctrl #(
    parameter int PC_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    cpu_ctrl_if.master bus,
    output logic       busy,
    output logic       halted
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALTED
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [5:0]      flags_q;

    logic       is_op;
    logic       is_br;
    logic       is_halt;
    logic       is_nop;
    logic [7:0] cond_vec;
    logic       taken;
    logic       launch;
    logic       in_exec;

    assign in_exec = (state_q == EXEC);
    assign launch  = start && (state_q == IDLE || state_q == HALTED);

    always_comb begin
        is_op   = 1'b0;
        is_br   = 1'b0;
        is_halt = 1'b0;
        is_nop  = 1'b0;
        unique case (1'b1)
            ir_q[15:14] == 2'b00: is_op   = 1'b1;
            ir_q[15:14] == 2'b01: is_br   = 1'b1;
            ir_q[15:14] == 2'b10: is_halt = 1'b1;
            default:              is_nop  = 1'b1;
        endcase
    end

    // cond 6 is always, cond 7 never
    assign cond_vec = {1'b0, 1'b1, flags_q};
    assign taken    = is_br && (cond_vec[ir_q[12:10]] ^ ir_q[13]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = is_halt ? HALTED : FETCH;
            HALTED:  if (start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // SAFE encoding rewrites r0 with itself; only OP in EXEC overrides it
    always_comb begin
        bus.wrA   = 1'b1;
        bus.selA  = 2'd0;
        bus.selB  = 2'd0;
        bus.aluOp = 2'd0;
        bus.imm   = 1'b0;
        bus.selR  = 2'd2;
        if (in_exec && is_op) begin
            bus.wrA   = ir_q[9];
            bus.selA  = ir_q[8:7];
            bus.selB  = ir_q[6:5];
            bus.aluOp = ir_q[4:3];
            bus.imm   = ir_q[2];
            bus.selR  = ir_q[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                pc_q    <= '0;
                flags_q <= '0;
            end
            if (state_q == DECODE) ir_q <= bus.instr_i;
            if (in_exec) begin
                if (taken) pc_q <= ir_q[PC_W-1:0];
                else if (!is_halt) pc_q <= pc_q + 1'b1;
                if (is_op && ir_q[1:0] == 2'd1) flags_q <= bus.cc_i;
            end
        end
    end

`ifdef CPU_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (launch) begin
            retired <= '0;
        end else if (in_exec && retired != 16'hFFFF) begin
            retired <= retired + 16'd1;
        end
    end
`endif

    assign bus.pc_o = pc_q;
    assign busy     = (state_q == FETCH) || (state_q == DECODE) || in_exec;
    assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: an ISA-level model pushes the expected
// fetch address and EXEC control bundle per instruction; the monitor pops them.
module tb_cpu_ctrl;

    localparam logic [9:0] SAFE = 10'b1_00_00_00_0_10;
    localparam logic [15:0] HALT = 16'h8000;
    localparam logic [15:0] NOP  = 16'hC000;

    typedef struct {
        logic [7:0] pc;
        logic [9:0] ctl;
        logic       halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start4;
    logic busy8, halted8, busy4, halted4;
`ifdef CPU_CTRL_PERF_EN
    logic [15:0] ret8, ret4;
`endif

    logic [15:0] rom8 [256];
    logic [15:0] rom4 [16];
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_ctrl_if #(.PC_W(8)) bus8 ();
    cpu_ctrl_if #(.PC_W(4)) bus4 ();

    cpu_ctrl #(.PC_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus8.master),
        .busy   (busy8),
        .halted (halted8)
`ifdef CPU_CTRL_PERF_EN
        ,
        .retired(ret8)
`endif
    );

    cpu_ctrl #(.PC_W(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .bus    (bus4.master),
        .busy   (busy4),
        .halted (halted4)
`ifdef CPU_CTRL_PERF_EN
        ,
        .retired(ret4)
`endif
    );

    always @(posedge clk) bus8.instr_i <= rom8[bus8.pc_o];
    always @(posedge clk) bus4.instr_i <= rom4[bus4.pc_o];
    assign bus4.cc_i = 6'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctl8();
        return {bus8.wrA, bus8.selA, bus8.selB, bus8.aluOp,
                bus8.imm, bus8.selR};
    endfunction

    function automatic logic [15:0] op(input logic w, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] alu,
                                       input logic i, input logic [1:0] r);
        return {6'b0, w, a, b, alu, i, r};
    endfunction

    function automatic logic [15:0] br(input logic inv, input logic [2:0] cond,
                                       input logic [7:0] tgt);
        return {2'b01, inv, cond, 2'b00, tgt};
    endfunction

    // ISA-level model of one run from pc 0 with cleared flags
    task automatic model(input logic [5:0] cc, input int max_n);
        logic [7:0]  pc;
        logic [5:0]  fl;
        logic [15:0] ir;
        logic [2:0]  cond;
        logic        t;
        exp_t        e;
        pc = 8'd0;
        fl = 6'd0;
        sb.delete();
        for (int i = 0; i < max_n; i++) begin
            ir = rom8[pc];
            e.pc = pc;
            e.halt = 1'b0;
            e.ctl = SAFE;
            case (ir[15:14])
                2'b00: begin
                    e.ctl = ir[9:0];
                    if (ir[1:0] == 2'd1) fl = cc;
                    pc = pc + 8'd1;
                end
                2'b01: begin
                    cond = ir[12:10];
                    if (cond == 3'd6) t = 1'b1;
                    else if (cond == 3'd7) t = 1'b0;
                    else t = fl[cond];
                    if (ir[13]) t = !t;
                    pc = t ? ir[7:0] : pc + 8'd1;
                end
                2'b10: e.halt = 1'b1;
                default: pc = pc + 8'd1;
            endcase
            sb.push_back(e);
            if (e.halt) break;
        end
    endtask

    // start pulse, then pop one expectation per 3-cycle instruction
    task automatic run8(input int poke);
        exp_t e;
        int idx = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("fetch_pc", 32'(bus8.pc_o), 32'(e.pc));
            check("fetch_busy", 32'(busy8), 32'd1);
            check("fetch_safe", 32'(ctl8()), 32'(SAFE));
            @(negedge clk);
            @(negedge clk);
            check("exec_ctl", 32'(ctl8()), 32'(e.ctl));
            if (idx == poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            idx++;
            if (e.halt) begin
                check("halted", 32'(halted8), 32'd1);
                check("halt_busy", 32'(busy8), 32'd0);
                check("halt_pc", 32'(bus8.pc_o), 32'(e.pc));
            end
        end
`ifdef CPU_CTRL_PERF_EN
        check("retired", 32'(ret8), 32'(idx));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        bus8.cc_i = 6'd0;
        for (int i = 0; i < 256; i++) rom8[i] = HALT;
        for (int i = 0; i < 16; i++) rom4[i] = NOP;
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'(ctl8()), 32'(SAFE));
        check("rst_pc", 32'(bus8.pc_o), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_halted", 32'(halted8), 32'd0);
`ifdef CPU_CTRL_PERF_EN
        check("rst_retired", 32'(ret8), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // OP then HALT
        rom8[0] = op(1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 2'd1);
        rom8[1] = HALT;
        bus8.cc_i = 6'b000001;
        model(6'b000001, 20);
        run8(-1);

        // flag 0 set by OP, branch taken / inverted
        rom8[1] = br(1'b0, 3'd0, 8'h20);
        model(6'b000001, 20);
        run8(-1);
        rom8[1] = br(1'b1, 3'd0, 8'h20);
        model(6'b000001, 20);
        run8(-1);

        // flag 5 branch
        bus8.cc_i = 6'b100000;
        rom8[1] = br(1'b0, 3'd5, 8'h20);
        model(6'b100000, 20);
        run8(-1);

        // OP with selR=2 keeps flags cleared by start
        bus8.cc_i = 6'b111111;
        rom8[0] = op(1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 2'd2);
        rom8[1] = br(1'b0, 3'd0, 8'h20);
        model(6'b111111, 20);
        run8(-1);

        // inverted never-condition is taken
        rom8[1] = br(1'b1, 3'd7, 8'h20);
        model(6'b111111, 20);
        run8(-1);

        // NOPs to HALT, start during EXEC ignored, restart from HALTED
        bus8.cc_i = 6'd0;
        rom8[0] = NOP;
        rom8[1] = NOP;
        rom8[2] = NOP;
        rom8[3] = HALT;
        model(6'd0, 20);
        run8(1);
        model(6'd0, 20);
        run8(-1);

        // 4-bit PC wraps from 15 to 0
        rom4[0] = br(1'b0, 3'd6, 8'h0F);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        check("w_pc0", 32'(bus4.pc_o), 32'd0);
        repeat (3) @(negedge clk);
        check("w_pc15", 32'(bus4.pc_o), 32'd15);
        repeat (3) @(negedge clk);
        check("w_wrap", 32'(bus4.pc_o), 32'd0);
        check("w_busy", 32'(busy4), 32'd1);

        // async reset in EXEC of a store OP at pc 1
        rom8[0] = NOP;
        rom8[1] = op(1'b0, 2'd3, 2'd1, 2'd2, 1'b1, 2'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check("x_ctl", 32'(ctl8()), 32'(op(1'b0, 2'd3, 2'd1, 2'd2, 1'b1, 2'd0)));
        check("x_pc", 32'(bus8.pc_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("x_wra", 32'(bus8.wrA), 32'd1);
        check("x_selr", 32'(bus8.selR), 32'd2);
        check("x_busy", 32'(busy8), 32'd0);
        check("x_rpc", 32'(bus8.pc_o), 32'd0);
        check("x_halted", 32'(halted8), 32'd0);
`ifdef CPU_CTRL_PERF_EN
        check("x_retired", 32'(ret8), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("x_idle", 32'(busy8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Sequencer directly upstream of the 8-bit cpu datapath.
- Holds the program counter and fetches 16-bit instructions from a synchronous instruction ROM.
- Decodes each instruction into the datapath control bundle: wrA, selA, selB, aluOp, imm, selR.
- Latches the datapath condition codes and uses them to resolve conditional branches.

Parameters:
PC_W, 8, program counter / ROM address width; legal range 1..8.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; starts execution from PC 0 when in IDLE or HALTED
instr_i  input  16  ROM read data; valid the cycle after pc_o is presented
cc_i  input  6  condition codes from the datapath ALU, combinational
pc_o  output  PC_W  ROM address
wrA  output  1  datapath register-write enable; 0 = memory/outReg store
selA  output  2  datapath register A select
selB  output  2  datapath register B select
aluOp  output  2  datapath ALU operation
imm  output  1  immediate select (1 gives -1, 0 gives +1 when selR=3)
selR  output  2  datapath result mux select
busy  output  1  high in FETCH, DECODE and EXEC
halted  output  1  high in HALTED

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, ir=0, flags=0, all outputs at the SAFE encoding, busy=0, halted=0.
- SAFE encoding: wrA=1, selA=0, selB=0, aluOp=0, imm=0, selR=2. The datapath then writes r0 with its own value, so no memory store and no state change. SAFE is driven in every state except EXEC.
- Instruction format (ir):
  - [15:14]=00 OP: wrA=ir[9], selA=ir[8:7], selB=ir[6:5], aluOp=ir[4:3], imm=ir[2], selR=ir[1:0].
  - [15:14]=01 BR: cond=ir[12:10], inv=ir[13], target=ir[PC_W-1:0].
  - [15:14]=10 HALT.
  - [15:14]=11 NOP.
- Branch condition: cond 0..5 tests flags[cond]; 6 is always true; 7 is never true. The taken decision is the tested value XOR inv.
- FSM: IDLE -start-> FETCH -> DECODE -> EXEC -> FETCH. HALT in EXEC -> HALTED; HALTED -start-> FETCH.
- Per-state actions:
  - FETCH: pc_o=pc; ROM samples the address.
  - DECODE: ir <= instr_i.
  - EXEC: OP drives the decoded fields for exactly one cycle; NOP and BR drive SAFE.
- Fixed cost of 3 cycles per instruction.
- PC update at end of EXEC: taken BR loads target; HALT leaves pc unchanged; otherwise pc <= pc+1, modulo 2^PC_W (wraps to 0).
- Flags: at end of EXEC, flags <= cc_i only for OP with selR=1. All other instructions hold flags.
- start from IDLE or HALTED: pc <= 0 and flags <= 0 on the same edge.
- start while busy is ignored. A held start re-triggers only from IDLE or HALTED.
- pc_o is a registered output equal to pc in every state.
- Reset asserted mid-EXEC: outputs return to SAFE asynchronously, the in-flight instruction is abandoned, and pc and flags are not updated.

Optional Feature:
- Macro CPU_CTRL_PERF_EN.
- Defined: adds output retired[15:0].
  - Reset to 0; cleared on start.
  - Increments at the end of every EXEC, including BR, NOP and HALT.
  - Saturates at 16'hFFFF.
- Undefined: no port and no counter; all other behaviour is identical.

Test Plan:
1. Reset, then start; ROM[0]=OP(wrA=1, selA=1, selB=2, aluOp=0, selR=1) -> pc_o=0 in FETCH. Two cycles later wrA=1, selA=1, selB=2, selR=1 for exactly one cycle, then SAFE. pc=1.
2. ROM[0]=OP with selR=1 while cc_i=6'b000001; ROM[1]=BR cond=0, inv=0, target=8'h20 -> the FETCH after the branch shows pc_o=8'h20. Repeat with inv=1 -> pc_o=2.
3. ROM[0]=OP with selR=2 while cc_i=6'b111111, then BR cond=0 -> branch not taken (flags hold 0 after start); pc_o=2.
4. PC_W=4, ROM[15]=NOP, start with pc forced to 15 via a BR target=15 -> next FETCH pc_o=0 (wrap).
5. ROM[3]=HALT -> halted=1 and busy=0; further start pulses while halted restart at pc_o=0. A start pulse during EXEC is ignored.
6. Assert rst in the EXEC cycle of an OP with wrA=0 -> wrA=1 and selR=2 immediately (async); state IDLE, pc=0; with CPU_CTRL_PERF_EN, retired=0.
